// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read mux: ready mask, hardwired-zero rule, optional write bypass.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_commit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = stored;
    if (!ready)
      data = '0;
    else if (ZERO_REG != 0 && addr == '0)
      data = '0;
    else if (BYPASS != 0 && wr_commit && wr_addr == addr)
      data = wr_data;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with reset-time clearing sweep, N read ports and a debug port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     startin,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     ready,
  output logic                     clr_done
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic              clr_done_nx;
  logic              wr_commit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // No reset on storage: the sweep zeroes it so it can map onto RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  assign ready = (state == ST_RUN);

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    clr_done_nx = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = wr_addr;
    mem_wd      = wr_data;
    wr_commit   = (state == ST_RUN) && !startin && wr_en &&
                  !(ZERO_REG != 0 && wr_addr == '0);
    if (!startin) begin
      case (state)
        ST_CLEAR: begin
          mem_we = 1'b1;
          mem_wa = ptr;
          mem_wd = '0;
          ptr_nx = ptr + 1'b1;
          if (ptr == '1) begin
            state_nx    = ST_RUN;
            clr_done_nx = 1'b1;
          end
        end
        ST_RUN: mem_we = wr_commit;
        default: state_nx = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      state    <= ST_CLEAR;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      clr_done <= clr_done_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .ready    (ready),
      .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
      .stored   (mem[rd_addr[i*ADDR_W +: ADDR_W]]),
      .wr_commit(wr_commit),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .data     (rd_data[i*DATA_W +: DATA_W])
    );
  end

  regfile_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (0),
    .ZERO_REG(ZERO_REG)
  ) u_dbg (
    .ready    (ready),
    .addr     (dbg_addr),
    .stored   (mem[dbg_addr]),
    .wr_commit(wr_commit),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data     (dbg_data)
  );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the CPU datapath, the successor to the fixed 32x32 two-read-port file. Configurable data width, depth and read-port count, an optional same-cycle write-to-read bypass, an optional hardwired zero register, and a debug read port. A reset-time clearing sweep zeroes every entry, one per cycle, so the storage can map to RAM without a bulk reset. A `ready` flag tells the core when the file may be used.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; DEPTH = 2**ADDR_W.
- `NUM_RD`, default 2: number of read ports (≥1).
- `BYPASS`, default 1: 1 = a committing write forwards to matching read ports in the same cycle.
- `ZERO_REG`, default 1: 1 = register 0 always reads 0 and ignores writes.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `startin` in 1: reset, synchronous, active-high.
- `rd_addr` in NUM_RD*ADDR_W: read addresses; port i is at [i*ADDR_W +: ADDR_W].
- `rd_data` out NUM_RD*DATA_W: read data; port i is at [i*DATA_W +: DATA_W].
- `wr_en` in 1: write request.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `dbg_addr` in ADDR_W: debug read address.
- `dbg_data` out DATA_W: debug read data, stored value only, never bypassed.
- `ready` out 1: clearing sweep done; the file is usable.
- `clr_done` out 1: one-cycle pulse when the sweep completes.

## Operation
- The FSM has two states: ST_CLEAR and ST_RUN. A sweep pointer `ptr` is ADDR_W bits wide.
- `startin`=1 at an edge: state←ST_CLEAR, ptr←0, ready←0, clr_done←0. This takes priority over everything else. Nothing is written to storage on that edge.
- ST_CLEAR with `startin`=0:
  - Each edge writes mem[ptr]←0 and increments ptr.
  - On the edge that clears ptr=DEPTH-1: state←ST_RUN, ready←1, clr_done←1.
- ST_RUN:
  - A write commits when `wr_en`=1 and not (ZERO_REG and wr_addr==0).
  - clr_done returns to 0 after its single cycle.
- In ST_CLEAR, `wr_en` is ignored and its data is dropped. It is not queued.
- Read port i (combinational), in priority order:
  - ready=0 → 0.
  - ZERO_REG and addr==0 → 0.
  - BYPASS and a committing write with wr_addr==addr → wr_data.
  - Otherwise → mem[addr].
- `dbg_data` follows the same rules minus bypass.
- Several read ports may hit the same address; all return identical data.
- `startin` asserted mid-sweep restarts the sweep from ptr=0.
- `startin` held high keeps ready=0, with no storage writes.
- Before the first `startin`, outputs are undefined. The core must assert `startin` at power-up.

## Timing
- Reset values: ready=0, clr_done=0, rd_data=0 on all ports, dbg_data=0.
- Sweep timing, with `startin` sampled high at edge k and low from edge k+1:
  - Edges k+1 … k+DEPTH clear entries 0 … DEPTH-1.
  - ready=1 and clr_done=1 after edge k+DEPTH.
  - clr_done=0 after edge k+DEPTH+1.
- Total startup is DEPTH cycles (32 for the default configuration).
- Read latency is 0 cycles: combinational from the address.
- A committed write appears in mem after the edge.
  - With BYPASS=1 it is also visible on rd_data in the same cycle.
  - With BYPASS=0 it is visible from the next cycle.
- Read-during-write with BYPASS=0 returns the old value.

## Structure
- Package `regfile_pkg` holds:
  - The state enum: ST_CLEAR, ST_RUN.
  - A function returning DEPTH from ADDR_W.
- Sub-module `regfile_rd_port` implements one read mux: the ready mask, the zero rule and the optional bypass compare.
  - It is instantiated NUM_RD times in a generate loop.
  - The debug path uses one more instance with its bypass forced off.
- Storage is a plain array with no reset, so it can be inferred as RAM.

## Test plan
- Reset sweep, defaults: pulse `startin` 1 cycle → ready=0 for exactly 32 cycles, then ready=1 with a clr_done pulse of 1 cycle. Every `dbg_addr` then reads 0.
- Zero register: in ST_RUN, write 0xDEADBEEF to reg 0 → rd_data[0] and dbg_data read 0 for addr 0. A write of 0x12 to reg 1 reads back 0x12.
- Bypass: BYPASS=1, write 0xA5A5A5A5 to reg 7 with rd_addr = {7,7} in the same cycle → both ports show 0xA5A5A5A5 in that cycle. With BYPASS=0 the same stimulus shows the old value, then 0xA5A5A5A5 next cycle.
- Write during clear: fill reg 5 with 0x55, assert `startin`, then issue wr_en to reg 5 with 0x99 at sweep cycle 3 → after ready, reg 5 reads 0.
- Mid-sweep restart: reassert `startin` at sweep cycle 10 → ready rises 32 cycles after the second deassertion, not earlier.
- Parameter corner: NUM_RD=3, ADDR_W=3, DATA_W=8, ZERO_REG=0 → the sweep takes 8 cycles, reg 0 is writable (0x3C reads back), and all 3 ports read independent addresses correctly.
